// File: rtl/plm_sched_pkg.sv
// Shared sizing helpers for the PLM scheduling kernels and their response router.
package plm_sched_pkg;

  function automatic int unsigned cons_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Request word: {wr, addr, data}.
  function automatic int unsigned req_width(input int unsigned aw, input int unsigned vw);
    return aw + vw + 1;
  endfunction

  function automatic int unsigned plm_input_width(input int unsigned aw, input int unsigned vw,
                                                  input int unsigned nb);
    return nb * req_width(aw, vw);
  endfunction

endpackage

// File: rtl/rr_response_router_if.sv
// Grant / PLM data / response bundle between the RR kernels, the PLM and the router.
interface rr_response_router_if
  import plm_sched_pkg::*;
#(
  parameter int unsigned VALUE_WIDTH = 8,
  parameter int unsigned NCONSUMERS  = 2,
  parameter int unsigned NKERNELS    = 2,
  parameter int unsigned CONS_W      = cons_w(NCONSUMERS)
);
  logic [NKERNELS-1:0]                   grant_valid;
  logic [NKERNELS-1:0][CONS_W-1:0]       grant_consumer;
  logic [NKERNELS-1:0]                   grant_wr;
  logic [NKERNELS-1:0][VALUE_WIDTH-1:0]  plm_outputs;
  logic [NCONSUMERS-1:0]                 req_ack;
  logic [NCONSUMERS-1:0]                 resp_valid;
  logic [NCONSUMERS-1:0]                 resp_wr;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data;
  logic                                  route_err;

  modport master (
    output grant_valid, grant_consumer, grant_wr, plm_outputs,
    input  req_ack, resp_valid, resp_wr, resp_data, route_err
  );

  modport slave (
    input  grant_valid, grant_consumer, grant_wr, plm_outputs,
    output req_ack, resp_valid, resp_wr, resp_data, route_err
  );
endinterface

// File: rtl/rr_response_router_tag_pipe.sv
// resp_tag_pipe: fixed-depth, non-stalling shift register carrying grant tags alongside the PLM.
module resp_tag_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [DEPTH-1:0][W-1:0] stage_q, stage_d;

  always_comb begin
    stage_d    = '0;
    stage_d[0] = d;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign q = stage_q[DEPTH-1];
endmodule

// File: rtl/rr_response_router.sv
// Routes PLM read data back to the consumer each RR kernel served, PLM_LATENCY+1 cycles later.
// Optional RESP_COLLISION_CHECK_EN: sticky route_err on output collisions / illegal consumer ids.
module rr_response_router
  import plm_sched_pkg::*;
#(
  parameter int unsigned VALUE_WIDTH = 8,
  parameter int unsigned NCONSUMERS  = 2,
  parameter int unsigned NBANKS      = 1,
  parameter int unsigned NPORTS      = 1,
  parameter int unsigned PLM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  rr_response_router_if.slave bus
);
  localparam int unsigned NKERNELS = NBANKS * NPORTS;
  localparam int unsigned CONS_W   = cons_w(NCONSUMERS);
  localparam int unsigned TAG_W    = CONS_W + 2;

  typedef struct packed {
    logic              valid;
    logic [CONS_W-1:0] consumer;
    logic              wr;
  } tag_t;

  if (PLM_LATENCY < 1) begin : g_bad_latency
    $error("rr_response_router: PLM_LATENCY must be >= 1");
  end

  logic [NKERNELS-1:0]                    legal;
  logic [NCONSUMERS-1:0]                  req_ack;
  tag_t [NKERNELS-1:0]                    tag_in, tag_out;
  logic [NCONSUMERS-1:0]                  resp_valid_q, resp_valid_d;
  logic [NCONSUMERS-1:0]                  resp_wr_q, resp_wr_d;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data_q, resp_data_d;

  // An id is legal only if it matches some consumer index, so illegal ids never ack.
  always_comb begin
    legal   = '0;
    req_ack = '0;
    tag_in  = '0;
    for (int unsigned k = 0; k < NKERNELS; k++) begin
      for (int unsigned c = 0; c < NCONSUMERS; c++) begin
        if (bus.grant_consumer[k] == CONS_W'(c)) begin
          legal[k] = 1'b1;
          if (bus.grant_valid[k] && !reset) req_ack[c] = 1'b1;
        end
      end
      tag_in[k].valid    = bus.grant_valid[k] & legal[k];
      tag_in[k].consumer = bus.grant_consumer[k];
      tag_in[k].wr       = bus.grant_wr[k];
    end
  end

  for (genvar k = 0; k < NKERNELS; k++) begin : g_pipe
    resp_tag_pipe #(.DEPTH(PLM_LATENCY), .W(TAG_W)) u_pipe (
      .clk   (clk),
      .reset (reset),
      .d     (tag_in[k]),
      .q     (tag_out[k])
    );
  end

  // resp_valid_d doubles as the "already claimed" mark so the lowest kernel wins.
  always_comb begin
    resp_valid_d = '0;
    resp_wr_d    = resp_wr_q;
    resp_data_d  = resp_data_q;
    for (int unsigned c = 0; c < NCONSUMERS; c++) begin
      for (int unsigned k = 0; k < NKERNELS; k++) begin
        if (tag_out[k].valid && tag_out[k].consumer == CONS_W'(c) && !resp_valid_d[c]) begin
          resp_valid_d[c] = 1'b1;
          resp_wr_d[c]    = tag_out[k].wr;
          resp_data_d[c]  = tag_out[k].wr ? '0 : bus.plm_outputs[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_q <= '0;
      resp_wr_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_wr_q    <= resp_wr_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.req_ack    = req_ack;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_wr    = resp_wr_q;
  assign bus.resp_data  = resp_data_q;

`ifdef RESP_COLLISION_CHECK_EN
  logic collision, illegal_grant;
  logic route_err_q, route_err_d;

  always_comb begin
    collision = 1'b0;
    for (int unsigned k = 1; k < NKERNELS; k++) begin
      for (int unsigned j = 0; j < k; j++) begin
        if (tag_out[k].valid && tag_out[j].valid && tag_out[k].consumer == tag_out[j].consumer)
          collision = 1'b1;
      end
    end
    illegal_grant = |(bus.grant_valid & ~legal);
    route_err_d   = route_err_q | collision | illegal_grant;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) route_err_q <= 1'b0;
    else       route_err_q <= route_err_d;
  end

  assign bus.route_err = route_err_q;

`ifndef SYNTHESIS
  int unsigned cycle_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= 0;
    else       cycle_q <= cycle_q + 1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < NKERNELS; k++) begin
        if (bus.grant_valid[k] && !legal[k])
          $error("route_err: cycle %0d kernel %0d illegal consumer %0d",
                 cycle_q, k, bus.grant_consumer[k]);
        for (int unsigned j = 0; j < k; j++) begin
          if (tag_out[k].valid && tag_out[j].valid && tag_out[k].consumer == tag_out[j].consumer)
            $error("route_err: cycle %0d kernel %0d collides on consumer %0d",
                   cycle_q, k, tag_out[k].consumer);
        end
      end
    end
  end
`endif
`else
  assign bus.route_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_response_router.sv
// Directed self-checking bench: three router instances (L=1/NC=2, L=3/NC=2, L=2/NC=3).
module tb_rr_response_router;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

`ifdef RESP_COLLISION_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  rr_response_router_if #(.VALUE_WIDTH(8), .NCONSUMERS(2), .NKERNELS(2)) if_a ();
  rr_response_router_if #(.VALUE_WIDTH(8), .NCONSUMERS(2), .NKERNELS(2)) if_b ();
  rr_response_router_if #(.VALUE_WIDTH(8), .NCONSUMERS(3), .NKERNELS(2)) if_c ();

  rr_response_router #(.VALUE_WIDTH(8), .NCONSUMERS(2), .NBANKS(1), .NPORTS(2), .PLM_LATENCY(1))
    u_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  rr_response_router #(.VALUE_WIDTH(8), .NCONSUMERS(2), .NBANKS(2), .NPORTS(1), .PLM_LATENCY(3))
    u_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  rr_response_router #(.VALUE_WIDTH(8), .NCONSUMERS(3), .NBANKS(1), .NPORTS(2), .PLM_LATENCY(2))
    u_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    if_a.grant_valid = '0; if_a.grant_consumer = '0; if_a.grant_wr = '0; if_a.plm_outputs = '0;
    if_b.grant_valid = '0; if_b.grant_consumer = '0; if_b.grant_wr = '0; if_b.plm_outputs = '0;
    if_c.grant_valid = '0; if_c.grant_consumer = '0; if_c.grant_wr = '0; if_c.plm_outputs = '0;
  endtask

  task automatic test_reset;
    checks++;
    if ({if_a.resp_valid, if_a.resp_wr, if_a.resp_data, if_a.route_err, if_a.req_ack} !== '0) begin
      errors++;
      $display("FAIL reset_a got %h exp 0",
               {if_a.resp_valid, if_a.resp_wr, if_a.resp_data, if_a.route_err, if_a.req_ack});
    end
    checks++;
    if ({if_b.resp_valid, if_b.resp_wr, if_b.resp_data, if_b.route_err} !== '0) begin
      errors++;
      $display("FAIL reset_b got %h exp 0", {if_b.resp_valid, if_b.resp_wr, if_b.resp_data, if_b.route_err});
    end
    checks++;
    if ({if_c.resp_valid, if_c.resp_wr, if_c.resp_data, if_c.route_err} !== '0) begin
      errors++;
      $display("FAIL reset_c got %h exp 0", {if_c.resp_valid, if_c.resp_wr, if_c.resp_data, if_c.route_err});
    end
  endtask

  // Grant in the very first cycle after reset release, k0 -> c1 read, L=1.
  task automatic test_read_l1;
    reset = 1'b0;
    if_a.grant_valid = 2'b01; if_a.grant_consumer[0] = 1'b1; if_a.grant_wr = 2'b00;
    #1;
    checks++;
    if (if_a.req_ack !== 2'b10) begin
      errors++; $display("FAIL t1_ack got %b exp 10", if_a.req_ack);
    end
    tick;
    if_a.grant_valid = '0; if_a.plm_outputs[0] = 8'hA5;
    checks++;
    if (if_a.resp_valid !== 2'b00) begin
      errors++; $display("FAIL t1_early got %b exp 00", if_a.resp_valid);
    end
    tick;
    if_a.plm_outputs = '0;
    checks++;
    if (if_a.resp_valid !== 2'b10 || if_a.resp_data[1] !== 8'hA5 || if_a.resp_wr[1] !== 1'b0) begin
      errors++; $display("FAIL t1_resp got v=%b d=%h w=%b exp v=10 d=a5 w=0",
                         if_a.resp_valid, if_a.resp_data[1], if_a.resp_wr[1]);
    end
    tick;
    checks++;
    if (if_a.resp_valid !== 2'b00 || if_a.resp_data[1] !== 8'hA5) begin
      errors++; $display("FAIL t1_hold got v=%b d=%h exp v=00 d=a5", if_a.resp_valid, if_a.resp_data[1]);
    end
  endtask

  // L=3 write from k1 -> c0; plm_outputs held at FF must be ignored.
  task automatic test_write_l3;
    if_b.plm_outputs = {8'hFF, 8'hFF};
    if_b.grant_valid = 2'b10; if_b.grant_consumer[1] = 1'b0; if_b.grant_wr = 2'b10;
    #1;
    checks++;
    if (if_b.req_ack !== 2'b01) begin
      errors++; $display("FAIL t2_ack got %b exp 01", if_b.req_ack);
    end
    for (int t = 1; t <= 6; t++) begin
      tick;
      if_b.grant_valid = '0; if_b.grant_wr = '0;
      checks++;
      if (if_b.resp_valid !== ((t == 4) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL t2_valid cycle %0d got %b exp %b", t, if_b.resp_valid,
                           (t == 4) ? 2'b01 : 2'b00);
      end
      if (t == 4) begin
        checks++;
        if (if_b.resp_wr[0] !== 1'b1 || if_b.resp_data[0] !== 8'h00) begin
          errors++; $display("FAIL t2_wr got w=%b d=%h exp w=1 d=00", if_b.resp_wr[0], if_b.resp_data[0]);
        end
      end
    end
  endtask

  // Four back-to-back grants k0->c0, k1->c1; data 1..4 / 11..14 returned in order.
  task automatic test_back_to_back;
    for (int t = 0; t <= 6; t++) begin
      if_a.grant_valid = (t < 4) ? 2'b11 : 2'b00;
      if_a.grant_consumer[0] = 1'b0; if_a.grant_consumer[1] = 1'b1;
      if_a.plm_outputs[0] = (t >= 1 && t <= 4) ? 8'(t) : 8'h00;
      if_a.plm_outputs[1] = (t >= 1 && t <= 4) ? 8'(8'h10 + t) : 8'h00;
      #1;
      if (t >= 2 && t <= 5) begin
        checks++;
        if (if_a.resp_valid !== 2'b11 || if_a.resp_data[0] !== 8'(t - 1) ||
            if_a.resp_data[1] !== 8'(8'h10 + t - 1)) begin
          errors++; $display("FAIL t3_b2b cycle %0d got v=%b d0=%h d1=%h exp v=11 d0=%h d1=%h", t,
                             if_a.resp_valid, if_a.resp_data[0], if_a.resp_data[1],
                             8'(t - 1), 8'(8'h10 + t - 1));
        end
      end
      if (t == 6) begin
        checks++;
        if (if_a.resp_valid !== 2'b00) begin
          errors++; $display("FAIL t3_end got %b exp 00", if_a.resp_valid);
        end
      end
      tick;
    end
    clear_inputs();
  endtask

  // Both kernels target c0 in one cycle: kernel 0 wins.
  task automatic test_collision;
    if_a.grant_valid = 2'b11; if_a.grant_consumer = '0; if_a.grant_wr = '0;
    tick;
    if_a.grant_valid = '0; if_a.plm_outputs[0] = 8'h11; if_a.plm_outputs[1] = 8'h22;
    checks++;
    if (if_a.route_err !== 1'b0) begin
      errors++; $display("FAIL t4_err_pre got %b exp 0", if_a.route_err);
    end
    tick;
    if_a.plm_outputs = '0;
    checks++;
    if (if_a.resp_valid !== 2'b01 || if_a.resp_data[0] !== 8'h11) begin
      errors++; $display("FAIL t4_win got v=%b d=%h exp v=01 d=11", if_a.resp_valid, if_a.resp_data[0]);
    end
    checks++;
    if (if_a.route_err !== EXP_ERR) begin
      errors++; $display("FAIL t4_err got %b exp %b", if_a.route_err, EXP_ERR);
    end
    tick; tick;
    checks++;
    if (if_a.route_err !== EXP_ERR) begin
      errors++; $display("FAIL t4_sticky got %b exp %b", if_a.route_err, EXP_ERR);
    end
  endtask

  // L=2 grant to c2, then reset in the next cycle: the response must never appear.
  task automatic test_reset_flush;
    if_c.grant_valid = 2'b01; if_c.grant_consumer[0] = 2'd2;
    #1;
    checks++;
    if (if_c.req_ack !== 3'b100) begin
      errors++; $display("FAIL t5_ack got %b exp 100", if_c.req_ack);
    end
    tick;
    reset = 1'b1; if_c.plm_outputs[0] = 8'h5A;
    #1;
    checks++;
    if (if_c.req_ack !== 3'b000 || if_c.resp_valid !== 3'b000 || if_c.resp_data !== '0) begin
      errors++; $display("FAIL t5_in_reset got ack=%b v=%b d=%h exp 0", if_c.req_ack, if_c.resp_valid,
                         if_c.resp_data);
    end
    checks++;
    if (if_a.route_err !== 1'b0) begin
      errors++; $display("FAIL t5_err_clr got %b exp 0", if_a.route_err);
    end
    tick;
    reset = 1'b0;
    clear_inputs();
    if_c.plm_outputs = {8'h77, 8'h77};
    for (int t = 0; t < 5; t++) begin
      tick;
      checks++;
      if (if_c.resp_valid !== 3'b000 || if_c.resp_data !== '0) begin
        errors++; $display("FAIL t5_flush cycle %0d got v=%b d=%h exp 0", t, if_c.resp_valid, if_c.resp_data);
      end
    end
    if_c.plm_outputs = '0;
  endtask

  // Consumer id 3 with NC=3 is illegal: no ack, no response.
  task automatic test_illegal_id;
    checks++;
    if (if_c.route_err !== 1'b0) begin
      errors++; $display("FAIL t6_err_pre got %b exp 0", if_c.route_err);
    end
    if_c.grant_valid = 2'b01; if_c.grant_consumer[0] = 2'd3;
    #1;
    checks++;
    if (if_c.req_ack !== 3'b000) begin
      errors++; $display("FAIL t6_ack got %b exp 000", if_c.req_ack);
    end
    tick;
    if_c.grant_valid = '0; if_c.plm_outputs = {8'h99, 8'h99};
    checks++;
    if (if_c.route_err !== EXP_ERR) begin
      errors++; $display("FAIL t6_err got %b exp %b", if_c.route_err, EXP_ERR);
    end
    for (int t = 0; t < 4; t++) begin
      tick;
      checks++;
      if (if_c.resp_valid !== 3'b000) begin
        errors++; $display("FAIL t6_noresp cycle %0d got %b exp 000", t, if_c.resp_valid);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick; tick;
    test_reset();
    test_read_l1();
    test_write_l3();
    test_back_to_back();
    test_collision();
    test_reset_flush();
    test_illegal_id();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
